// File: rtl/board_word_entry_if.sv
// board_word_entry_if: assembled-word valid/ready handshake towards the CPU side.
interface board_word_entry_if;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;
    modport master (output word, word_valid, input word_ready);
    modport slave (input word, word_valid, output word_ready);
endinterface

// File: rtl/board_word_entry.sv
// board_word_entry: debounced switch/button byte entry assembling 32-bit words for the CPU.
module board_word_entry #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sw,
    input  logic               btn_load,
    input  logic               btn_clr,
    output logic [1:0]         byte_idx,
    output logic               busy,
    board_word_entry_if.master out
);
    typedef enum logic {COLLECT, HOLD} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] s1, s2, deb, ev;
    logic [CNT_W-1:0] cnt [2];
    logic ld, clr;
    state_t state, state_n;
    logic [31:0] shadow, shadow_n, word_n;
    logic [1:0] idx_n;
    // bit 0 = load button, bit 1 = clear button
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            deb <= '0;
            cnt <= '{default: '0};
        end else begin
            s1 <= {btn_clr, btn_load};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= s2[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    // the press event coincides with the edge that raises the debounced level
    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++) ev[i] = s2[i] & ~deb[i] & (cnt[i] == LAST);
    end
    assign ld = ev[0];
    assign clr = ev[1];
    always_comb begin
        state_n = state;
        idx_n = byte_idx;
        shadow_n = shadow;
        word_n = out.word;
        if (state == HOLD) begin
            if (out.word_ready || clr) state_n = COLLECT;
        end else if (clr) begin
            shadow_n = '0;
            idx_n = '0;
        end else if (ld) begin
            shadow_n[{byte_idx, 3'b000} +: 8] = sw;
            idx_n = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
                word_n = {sw, shadow[23:0]};
                state_n = HOLD;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            byte_idx <= '0;
            shadow <= '0;
            out.word <= '0;
        end else begin
            state <= state_n;
            byte_idx <= idx_n;
            shadow <= shadow_n;
            out.word <= word_n;
        end
    end
    assign out.word_valid = (state == HOLD);
    assign busy = |byte_idx;
endmodule

// File: tb/tb_board_word_entry.sv
// tb_board_word_entry: directed and randomized word-entry scenarios against a byte-lane reference model.
module tb_board_word_entry;
    localparam int DC = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] sw = '0;
    logic btn_load = 1'b0;
    logic btn_clr = 1'b0;
    logic [1:0] byte_idx;
    logic busy;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] m_lane [4];
    int m_idx = 0;
    logic [31:0] m_word = '0;
    logic m_valid = 1'b0;

    board_word_entry_if bus();

    board_word_entry #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn_load(btn_load),
        .btn_clr(btn_clr),
        .byte_idx(byte_idx),
        .busy(busy),
        .out(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_idx"}, 32'(byte_idx), 32'(m_idx));
        check({tag, "_busy"}, 32'(busy), 32'(m_idx != 0));
        check({tag, "_valid"}, 32'(bus.word_valid), 32'(m_valid));
        check({tag, "_word"}, bus.word, m_word);
    endtask

    task automatic m_clear_lanes();
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
    endtask

    // one debounced event in the reference model; clear beats load
    task automatic m_event(input bit ld, input bit cl);
        if (m_valid) begin
            if (cl) m_valid = 1'b0;
        end else if (cl) begin
            m_idx = 0;
            m_clear_lanes();
        end else if (ld) begin
            m_lane[m_idx] = sw;
            if (m_idx == 3) begin
                m_word = 32'(m_lane[0]) + (32'(m_lane[1]) << 8) + (32'(m_lane[2]) << 16) + (32'(m_lane[3]) << 24);
                m_valid = 1'b1;
                m_idx = 0;
            end else m_idx++;
        end
    endtask

    // clean press: event lands 2+DC edges after the first sampling edge
    task automatic press(input bit ld, input bit cl, input logic [7:0] v);
        @(negedge clk);
        sw = v;
        btn_load = ld;
        btn_clr = cl;
        repeat (DC + 1) @(posedge clk);
        #1 check_state("pre");
        @(posedge clk);
        #1 m_event(ld, cl);
        check_state("post");
        repeat (DC + 4) @(posedge clk);
        #1 btn_load = 1'b0;
        btn_clr = 1'b0;
        repeat (DC + 6) @(posedge clk);
        #1 check_state("settled");
    endtask

    task automatic deliver(input int wait_n);
        repeat (wait_n) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.word_valid), 32'd1);
            check("hold_word", bus.word, m_word);
        end
        @(negedge clk);
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        m_valid = 1'b0;
        check_state("delivered");
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_idx = 0;
        m_valid = 1'b0;
        m_word = '0;
        m_clear_lanes();
        check_state(tag);
    endtask

    initial begin
        bus.word_ready = 1'b0;
        m_clear_lanes();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_state("reset");

        press(1, 0, 8'h78);
        press(1, 0, 8'h56);
        press(1, 0, 8'h34);
        press(1, 0, 8'h12);
        check("word_12345678", bus.word, 32'h1234_5678);
        deliver(20);

        @(negedge clk);
        sw = 8'hA5;
        for (int t = 0; t < 30;) begin
            int h;
            int l;
            h = $urandom_range(1, 2);
            l = $urandom_range(1, 2);
            btn_load = 1'b1;
            repeat (h) @(negedge clk);
            btn_load = 1'b0;
            repeat (l) @(negedge clk);
            t += h + l;
        end
        check_state("bounce_quiet");
        btn_load = 1'b1;
        repeat (DC + 8) @(posedge clk);
        #1 m_event(1, 0);
        check_state("bounce_one");
        btn_load = 1'b0;
        repeat (DC + 6) @(posedge clk);
        #1 check_state("bounce_release");

        press(1, 0, 8'h11);
        press(0, 1, 8'h00);
        press(1, 0, 8'hEF);
        press(1, 0, 8'hBE);
        press(1, 0, 8'hAD);
        press(1, 0, 8'hDE);
        check("word_deadbeef", bus.word, 32'hDEAD_BEEF);
        press(1, 0, 8'hFF);

        @(negedge clk);
        btn_clr = 1'b1;
        repeat (DC + 1) @(posedge clk);
        #1 check_state("rc_pre");
        bus.word_ready = 1'b1;
        @(posedge clk);
        #1 bus.word_ready = 1'b0;
        m_event(0, 1);
        check_state("rc_post");
        repeat (DC + 4) @(posedge clk);
        #1 btn_clr = 1'b0;
        repeat (DC + 6) @(posedge clk);

        press(1, 0, 8'h42);
        press(1, 1, 8'h99);

        for (int i = 0; i < 3; i++) press(1, 0, 8'($urandom));
        do_reset("rst_partial");
        for (int i = 0; i < 4; i++) press(1, 0, 8'($urandom));
        do_reset("rst_hold");

        for (int w = 0; w < 5; w++) begin
            int n;
            n = 0;
            while (!m_valid && n < 12) begin
                bus.word_ready = (m_idx < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                if ($urandom_range(0, 7) == 0) press(0, 1, 8'($urandom));
                else press(1, 0, 8'($urandom));
                n++;
            end
            bus.word_ready = 1'b0;
            if (m_valid) deliver($urandom_range(0, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/board_word_entry.md
Name: board_word_entry

Overview:
- Board-side input path for the Nexys 3 CPU experiments. It is the inbound counterpart of the LED readout wrapper.
- The operator sets a byte on 8 slide switches and presses a load button. Four presses assemble one 32-bit word, least significant byte first.
- The finished word goes to the CPU side (instruction or operand injection) through a valid/ready handshake.
- A clear button discards a partially entered word or a held word.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a button level change (1 ms at 100 MHz). Benches override it to a small value.
- CNT_W, 17, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- SW  in  8  byte value, sampled on the load press event.
- BTN_LOAD  in  1  raw asynchronous load push-button, active high.
- BTN_CLR  in  1  raw asynchronous clear push-button, active high.
- WORD  out  32  assembled word, registered.
- WORD_VALID  out  1  WORD is held and offered to the consumer.
- WORD_READY  in  1  consumer accepts WORD this cycle.
- BYTE_IDX  out  2  next byte lane to fill (0..3), for LED feedback.
- BUSY  out  1  high while 1..3 bytes of a word are entered.

Behaviour:
- Reset: WORD=0, WORD_VALID=0, BYTE_IDX=0, BUSY=0. The shadow word, both synchronizer chains, the debounced levels and the counters are all cleared.
- Input conditioning, per button:
  - Two-flop synchronizer, then a debouncer.
  - The debounce counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced level takes the synced value and the counter clears.
  - A press event is a one-cycle pulse on a 0->1 change of the debounced level. Releases generate nothing. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: COLLECT (reset state) and HOLD.
- COLLECT, load event:
  - SW is written into shadow lane BYTE_IDX (lane 0 = bits 7:0).
  - If BYTE_IDX<3: BYTE_IDX increments and BUSY=1.
  - If BYTE_IDX==3: WORD <= {SW, shadow[23:0]}, BYTE_IDX wraps to 0, BUSY=0, WORD_VALID=1 from the next cycle, state goes to HOLD.
- COLLECT, clear event: shadow=0, BYTE_IDX=0, BUSY=0. WORD is unchanged.
- COLLECT, other: WORD_READY is ignored.
- HOLD:
  - WORD_VALID=1 and WORD is stable.
  - Load events are ignored and dropped, not queued. SW is not sampled.
  - WORD_VALID & WORD_READY in a cycle: the transfer completes, WORD_VALID=0 next cycle, state goes to COLLECT. WORD keeps its last value.
  - Clear event: WORD_VALID=0 next cycle, state goes to COLLECT, WORD is unchanged, no transfer.
- Simultaneous events:
  - Load and clear in the same cycle: clear wins and the load is dropped.
  - In HOLD, WORD_READY and clear in the same cycle: the transfer completes. Both actions return the block to COLLECT.
- Latency: from a raw press held stable, the load event occurs 2 + DEBOUNCE_CYCLES cycles after the first sampling edge, ±1 cycle.
- Reset mid-entry or mid-HOLD: all state returns to the reset values on that edge. Any partial or held word is lost and no transfer is signalled.
- Only the single clock domain exists; BTN_* are the only asynchronous inputs. SW is quasi-static and is sampled without synchronization.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then four clean presses with SW=0x78,0x56,0x34,0x12 -> BYTE_IDX steps 1,2,3,0 and BUSY is high after presses 1-3. WORD_VALID=1 with WORD=0x12345678 one cycle after the 4th event.
- Hold WORD_READY=0 for 20 cycles, then pulse it for 1 cycle -> WORD_VALID stays 1 and WORD stays 0x12345678 throughout. WORD_VALID=0 the next cycle and the FSM returns to COLLECT.
- Bounce BTN_LOAD with 1-2 cycle pulses for 30 cycles, then hold it high -> exactly one load event and BYTE_IDX advances by exactly 1.
- Enter 2 bytes, then press clear -> BYTE_IDX=0 and BUSY=0. Four further bytes 0xEF,0xBE,0xAD,0xDE -> WORD=0xDEADBEEF with no stale lanes.
- In HOLD, press load with SW=0xFF -> ignored: WORD is unchanged and BYTE_IDX=0. Load and clear debounced in the same cycle during COLLECT -> clear wins, BYTE_IDX=0.
- Assert RST with 3 bytes entered, and separately during HOLD -> next cycle WORD=0, WORD_VALID=0, BYTE_IDX=0, BUSY=0.
